layer_sequencer: RTL and testbench
==================================

// Module: layer_sequencer
// PURPOSE
//  Top-level inference scheduler: runs NUM_LAYERS layer engines (conv, fc1, fc2, ...) strictly in order,
//  one at a time, via their ena / iRst_n inputs, and muxes the single shared weight-ROM address bus from the active engine.
//  Sits between the board-level start/result logic and the layer engines; the shared MultAdder needs no arbitration
//  because only one engine is enabled at any time.
// PARAMETERS
//  NUM_LAYERS  3       number of layer engines, run in index order 0..NUM_LAYERS-1
//  ROM_AW      11      width of each engine's ROM address and of the muxed ROM address
//  TIMEOUT     200000  max cycles a layer may run before done; 0 disables the watchdog
//  LW          2       width of layer index, must satisfy 2**LW >= NUM_LAYERS
// PORTS
//  clk          in   1                  system clock
//  iRst_n       in   1                  synchronous, active-low reset
//  start        in   1                  one-cycle pulse: begin inference
//  layer_done   in   NUM_LAYERS         per-engine done flags (level)
//  layer_addr   in   NUM_LAYERS*ROM_AW  per-engine ROM addresses; engine k at [k*ROM_AW +: ROM_AW]
//  layer_ena    out  NUM_LAYERS         per-engine enable, one-hot or all zero
//  layer_rst_n  out  NUM_LAYERS         per-engine synchronous reset, active-low
//  addr_to_rom  out  ROM_AW             muxed ROM address
//  active_layer out  LW                 index of the engine currently armed or running
//  busy         out  1                  high from ARM of layer 0 until FINISH or ERROR
//  done         out  1                  high in FINISH: all layers completed
//  timeout_err  out  1                  high in ERROR: watchdog expired
//  err_layer    out  LW                 index of the layer that timed out
//  cycle_count  out  32                 cycles spent in ARM+RUN for the current or last inference
// BEHAVIOUR
//  Reset, while iRst_n=0 at a clk edge: state=IDLE; layer_ena=0; layer_rst_n=all 1; addr_to_rom=0;
//   active_layer=0; busy=done=timeout_err=0; err_layer=0; cycle_count=0; watchdog=0.
//   Reset mid-inference aborts immediately; the next cycle has no engine enabled.
//  All outputs are registered. State encoding is free. States:
//   IDLE   : wait for start. On start -> ARM(0); clear cycle_count, done, timeout_err.
//   ARM(k) : exactly 1 cycle; layer_ena[k]=1 and layer_rst_n[k]=0, which clears engine k's counters and done.
//            Then -> RUN(k) with watchdog=0.
//   RUN(k) : layer_ena[k]=1 and layer_rst_n[k]=1. addr_to_rom = layer_addr slice k, passed through combinationally in RUN only.
//            The watchdog increments each cycle.
//            If layer_done[k]=1: if k==NUM_LAYERS-1 -> FINISH, else -> ARM(k+1) on the next cycle. layer_ena[k] drops
//              on the same edge, so the engine keeps its data_to_ram contents and the next engine reads them.
//            Else if TIMEOUT!=0 and watchdog==TIMEOUT-1 -> ERROR; err_layer=k.
//            If layer_done[k] and watchdog expiry occur on the same cycle, done wins.
//   FINISH : layer_ena=0; done=1; busy=0. A start pulse -> ARM(0), clearing done on that edge.
//   ERROR  : layer_ena=0; timeout_err=1; busy=0. A start pulse -> ARM(0), clearing timeout_err and err_layer.
//  start is ignored in ARM and RUN; there is no queueing.
//  layer_done inputs are only sampled for the active k. A stale done from a non-active engine is ignored.
//  Because ARM resets engine k, a done left high from a previous run is never seen in RUN(k).
//  Outside RUN, addr_to_rom=0. layer_ena is never more than one-hot; this property must be checked with an assertion.
//  cycle_count increments in ARM and RUN, saturates at 32'hFFFF_FFFF, and holds in FINISH, ERROR and IDLE.
//  Latency: start at cycle t gives ARM(0) at t+1 and RUN(0) at t+2.
//   For each layer: done seen at cycle d gives the next ARM at d+1.
//   Total cycles = sum over layers of (1 + run cycles incl. done cycle).
// TESTING
//  1) Reset, start pulse, engines model done after 5/7/3 RUN cycles -> ena order 001,010,100; each rst_n pulse 1 cycle;
//     done=1 with cycle_count=18.
//  2) addr mux: engine1 drives 11'h3A5, others 11'h7FF -> addr_to_rom=11'h3A5 only in RUN(1), 0 in ARM/IDLE/FINISH.
//  3) TIMEOUT=16, engine 1 never asserts done -> ERROR after 16 RUN(1) cycles; timeout_err=1, err_layer=1, layer_ena=0.
//  4) start pulsed during RUN(0), and stale layer_done[2]=1 during RUN(0) -> both ignored; sequence completes normally.
//  5) iRst_n low for 1 cycle during RUN(1) -> next cycle layer_ena=0, busy=0, state IDLE; new start runs from layer 0.
//  6) done and watchdog expiry on the same cycle -> advances to ARM(next), timeout_err stays 0; then FINISH, then restart.

Source files
------------

// File: rtl/layer_sequencer.sv
// Inference scheduler: runs the layer engines strictly in index order, one at a time, and muxes
// the shared weight-ROM address from whichever engine is running.
module layer_sequencer #(
   parameter int unsigned NUM_LAYERS = 3,
   parameter int unsigned ROM_AW     = 11,
   parameter int unsigned TIMEOUT    = 200000,
   parameter int unsigned LW         = 2
) (
   input  logic                           clk,
   input  logic                           iRst_n,
   input  logic                           start,
   input  logic [NUM_LAYERS-1:0]          layer_done,
   input  logic [NUM_LAYERS*ROM_AW-1:0]   layer_addr,
   output logic [NUM_LAYERS-1:0]          layer_ena,
   output logic [NUM_LAYERS-1:0]          layer_rst_n,
   output logic [ROM_AW-1:0]              addr_to_rom,
   output logic [LW-1:0]                  active_layer,
   output logic                           busy,
   output logic                           done,
   output logic                           timeout_err,
   output logic [LW-1:0]                  err_layer,
   output logic [31:0]                    cycle_count
);

   typedef enum logic [2:0] {StIdle, StArm, StRun, StFinish, StError} state_e;

   state_e                  state_q, state_d;
   logic [LW-1:0]           layer_q, layer_d;
   logic [31:0]             wdog_q, wdog_d;
   logic [NUM_LAYERS-1:0]   ena_q, ena_d;
   logic [NUM_LAYERS-1:0]   rst_n_q, rst_n_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    terr_q, terr_d;
   logic [LW-1:0]           err_layer_q, err_layer_d;
   logic [31:0]             cycle_count_q, cycle_count_d;

   logic                    sel_done;
   logic [ROM_AW-1:0]       sel_addr;
   logic                    last_layer;
   logic                    wdog_expired;

   // Only the active engine's done flag and address are ever looked at.
   always_comb begin
      sel_done = 1'b0;
      sel_addr = '0;
      for (int k = 0; k < int'(NUM_LAYERS); k++) begin
         if (layer_q == LW'(k)) begin
            sel_done = layer_done[k];
            sel_addr = layer_addr[k*ROM_AW +: ROM_AW];
         end
      end
   end

   assign last_layer   = (layer_q == LW'(NUM_LAYERS - 1));
   assign wdog_expired = (TIMEOUT != 0) && (wdog_q == 32'(TIMEOUT - 1));

   always_comb begin
      state_d       = state_q;
      layer_d       = layer_q;
      wdog_d        = wdog_q;
      err_layer_d   = err_layer_q;
      cycle_count_d = cycle_count_q;

      unique case (state_q)
         StIdle, StFinish, StError: begin
            if (start) begin
               state_d       = StArm;
               layer_d       = '0;
               err_layer_d   = '0;
               cycle_count_d = '0;
            end
         end
         StArm: begin
            state_d = StRun;
            wdog_d  = '0;
         end
         StRun: begin
            wdog_d = wdog_q + 32'd1;
            // A done arriving on the expiry cycle still counts as success.
            if (sel_done) begin
               if (last_layer) begin
                  state_d = StFinish;
               end else begin
                  state_d = StArm;
                  layer_d = layer_q + LW'(1);
               end
            end else if (wdog_expired) begin
               state_d     = StError;
               err_layer_d = layer_q;
            end
         end
         default: state_d = StIdle;
      endcase

      if ((state_q == StArm || state_q == StRun) && (cycle_count_q != 32'hFFFF_FFFF)) begin
         cycle_count_d = cycle_count_q + 32'd1;
      end

      // Engine controls are registered from the next state so they line up with it.
      ena_d   = '0;
      rst_n_d = '1;
      for (int k = 0; k < int'(NUM_LAYERS); k++) begin
         if (layer_d == LW'(k)) begin
            if (state_d == StArm) begin
               ena_d[k]   = 1'b1;
               rst_n_d[k] = 1'b0;
            end else if (state_d == StRun) begin
               ena_d[k] = 1'b1;
            end
         end
      end
      busy_d = (state_d == StArm) || (state_d == StRun);
      done_d = (state_d == StFinish);
      terr_d = (state_d == StError);
   end

   always_ff @(posedge clk) begin
      if (!iRst_n) begin
         state_q       <= StIdle;
         layer_q       <= '0;
         wdog_q        <= '0;
         ena_q         <= '0;
         rst_n_q       <= '1;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         terr_q        <= 1'b0;
         err_layer_q   <= '0;
         cycle_count_q <= '0;
      end else begin
         state_q       <= state_d;
         layer_q       <= layer_d;
         wdog_q        <= wdog_d;
         ena_q         <= ena_d;
         rst_n_q       <= rst_n_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         terr_q        <= terr_d;
         err_layer_q   <= err_layer_d;
         cycle_count_q <= cycle_count_d;
      end
   end

   assign layer_ena    = ena_q;
   assign layer_rst_n  = rst_n_q;
   assign addr_to_rom  = (state_q == StRun) ? sel_addr : '0;
   assign active_layer = layer_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign timeout_err  = terr_q;
   assign err_layer    = err_layer_q;
   assign cycle_count  = cycle_count_q;

   ena_onehot_a: assert property (@(posedge clk) $onehot0(ena_q));

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: per-cycle vector table for full runs, plus hand sequences
// for timeout, done-vs-timeout tie and mid-run reset.
module tb_layer_sequencer;

   localparam int unsigned NL = 3;
   localparam int unsigned AW = 11;
   localparam int unsigned TO = 16;
   localparam int unsigned LW = 2;

   logic            clk = 1'b0;
   logic            iRst_n;
   logic            start;
   logic [NL-1:0]   layer_done;
   logic [NL*AW-1:0] layer_addr;
   logic [NL-1:0]   layer_ena;
   logic [NL-1:0]   layer_rst_n;
   logic [AW-1:0]   addr_to_rom;
   logic [LW-1:0]   active_layer;
   logic            busy;
   logic            done;
   logic            timeout_err;
   logic [LW-1:0]   err_layer;
   logic [31:0]     cycle_count;

   int checks = 0;
   int errors = 0;

   int            cnt[NL];
   int            lim[NL];
   logic [NL-1:0] never_m;
   logic [NL-1:0] stale_m;

   always #5 clk = ~clk;

   layer_sequencer #(
      .NUM_LAYERS(NL),
      .ROM_AW    (AW),
      .TIMEOUT   (TO),
      .LW        (LW)
   ) dut (
      .clk         (clk),
      .iRst_n      (iRst_n),
      .start       (start),
      .layer_done  (layer_done),
      .layer_addr  (layer_addr),
      .layer_ena   (layer_ena),
      .layer_rst_n (layer_rst_n),
      .addr_to_rom (addr_to_rom),
      .active_layer(active_layer),
      .busy        (busy),
      .done        (done),
      .timeout_err (timeout_err),
      .err_layer   (err_layer),
      .cycle_count (cycle_count)
   );

   assign layer_addr = {11'h7FF, 11'h3A5, 11'h7FF};

   // Engine model: counter cleared by its rst_n, advances while enabled; done is a level.
   always @(posedge clk) begin
      for (int k = 0; k < int'(NL); k++) begin
         if (!iRst_n || !layer_rst_n[k]) cnt[k] <= 0;
         else if (layer_ena[k]) cnt[k] <= cnt[k] + 1;
      end
   end

   always_comb begin
      layer_done = stale_m;
      for (int k = 0; k < int'(NL); k++) begin
         if (!never_m[k] && (cnt[k] >= lim[k] - 1)) layer_done[k] = 1'b1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done && n < 200) begin
         tick();
         n++;
      end
      chk(name, 32'(done), 32'd1);
   endtask

   typedef struct {
      logic          start;
      logic [NL-1:0] stale;
      logic [NL-1:0] ena;
      logic [NL-1:0] rst_n;
      logic [AW-1:0] addr;
      logic          busy;
      logic          dn;
      logic [LW-1:0] act;
      logic [31:0]   cc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic st, logic [NL-1:0] stl, logic [NL-1:0] en, logic [NL-1:0] rn,
                               logic [AW-1:0] ad, logic bz, logic dn, logic [LW-1:0] ac,
                               logic [31:0] cc);
      vec_t v;
      v.start = st; v.stale = stl; v.ena = en; v.rst_n = rn; v.addr = ad;
      v.busy = bz; v.dn = dn; v.act = ac; v.cc = cc;
      return v;
   endfunction

   initial begin
      int            run_len[NL];
      logic [AW-1:0] eaddr[NL];
      logic [NL-1:0] oh;
      logic [31:0]   cc;
      logic          st;
      logic [NL-1:0] stl;

      run_len = '{5, 7, 3};
      eaddr   = '{11'h7FF, 11'h3A5, 11'h7FF};
      cc      = 0;
      // Pass 0 from IDLE; pass 1 restarts from FINISH with a stray start and stale done[2].
      for (int p = 0; p < 2; p++) begin
         vecs.push_back(mk(1'b1, '0, '0, '1, '0, 1'b0, (p == 1), '0, cc));
         cc = 0;
         for (int k = 0; k < int'(NL); k++) begin
            oh = 3'b001 << k;
            vecs.push_back(mk(1'b0, '0, oh, ~oh, '0, 1'b1, 1'b0, LW'(k), cc));
            cc++;
            for (int r = 0; r < run_len[k]; r++) begin
               st  = (p == 1) && (k == 0) && (r == 1);
               stl = st ? 3'b100 : 3'b000;
               vecs.push_back(mk(st, stl, oh, '1, eaddr[k], 1'b1, 1'b0, LW'(k), cc));
               cc++;
            end
         end
      end
      vecs.push_back(mk(1'b0, '0, '0, '1, '0, 1'b0, 1'b1, '0, cc));

      lim     = '{5, 7, 3};
      never_m = '0;
      stale_m = '0;
      iRst_n  = 1'b0;
      start   = 1'b1;
      tick();
      tick();
      chk("rst ena", 32'(layer_ena), 32'd0);
      chk("rst rst_n", 32'(layer_rst_n), 32'h7);
      chk("rst addr", 32'(addr_to_rom), 32'd0);
      chk("rst active", 32'(active_layer), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst terr", 32'(timeout_err), 32'd0);
      chk("rst errl", 32'(err_layer), 32'd0);
      chk("rst cc", cycle_count, 32'd0);
      start  = 1'b0;
      iRst_n = 1'b1;

      foreach (vecs[i]) begin
         start   = vecs[i].start;
         stale_m = vecs[i].stale;
         chk($sformatf("v%0d ena", i), 32'(layer_ena), 32'(vecs[i].ena));
         chk($sformatf("v%0d rst_n", i), 32'(layer_rst_n), 32'(vecs[i].rst_n));
         chk($sformatf("v%0d addr", i), 32'(addr_to_rom), 32'(vecs[i].addr));
         chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].busy));
         chk($sformatf("v%0d done", i), 32'(done), 32'(vecs[i].dn));
         chk($sformatf("v%0d cc", i), cycle_count, vecs[i].cc);
         chk($sformatf("v%0d terr", i), 32'(timeout_err), 32'd0);
         if (vecs[i].busy) chk($sformatf("v%0d active", i), 32'(active_layer), 32'(vecs[i].act));
         tick();
      end
      start   = 1'b0;
      stale_m = '0;

      // Watchdog: engine 1 never finishes.
      never_m = 3'b010;
      pulse_start();
      repeat (6) tick();
      chk("to arm1 ena", 32'(layer_ena), 32'h2);
      chk("to arm1 rst_n", 32'(layer_rst_n), 32'h5);
      repeat (16) tick();
      chk("to run16 ena", 32'(layer_ena), 32'h2);
      chk("to run16 terr", 32'(timeout_err), 32'd0);
      chk("to run16 busy", 32'(busy), 32'd1);
      tick();
      chk("to err ena", 32'(layer_ena), 32'd0);
      chk("to err terr", 32'(timeout_err), 32'd1);
      chk("to err errl", 32'(err_layer), 32'd1);
      chk("to err busy", 32'(busy), 32'd0);
      chk("to err done", 32'(done), 32'd0);
      chk("to err addr", 32'(addr_to_rom), 32'd0);
      chk("to err cc", cycle_count, 32'd23);
      tick();
      chk("to hold terr", 32'(timeout_err), 32'd1);
      chk("to hold cc", cycle_count, 32'd23);

      // Done on the same cycle the watchdog would expire.
      never_m = '0;
      lim[0]  = 16;
      pulse_start();
      chk("tie arm0 terr", 32'(timeout_err), 32'd0);
      chk("tie arm0 errl", 32'(err_layer), 32'd0);
      chk("tie arm0 cc", cycle_count, 32'd0);
      chk("tie arm0 ena", 32'(layer_ena), 32'h1);
      repeat (16) tick();
      chk("tie run16 ena", 32'(layer_ena), 32'h1);
      tick();
      chk("tie arm1 ena", 32'(layer_ena), 32'h2);
      chk("tie arm1 rst_n", 32'(layer_rst_n), 32'h5);
      chk("tie arm1 terr", 32'(timeout_err), 32'd0);
      chk("tie arm1 active", 32'(active_layer), 32'd1);
      wait_done("tie finish");
      chk("tie fin cc", cycle_count, 32'd29);
      chk("tie fin terr", 32'(timeout_err), 32'd0);
      pulse_start();
      lim[0] = 5;
      chk("restart ena", 32'(layer_ena), 32'h1);
      chk("restart done", 32'(done), 32'd0);
      chk("restart cc", cycle_count, 32'd0);

      // Reset in the middle of RUN(1).
      repeat (6) tick();
      tick();
      chk("mr run1 ena", 32'(layer_ena), 32'h2);
      chk("mr run1 addr", 32'(addr_to_rom), 32'h3A5);
      iRst_n = 1'b0;
      tick();
      iRst_n = 1'b1;
      chk("mr ena", 32'(layer_ena), 32'd0);
      chk("mr busy", 32'(busy), 32'd0);
      chk("mr rst_n", 32'(layer_rst_n), 32'h7);
      chk("mr addr", 32'(addr_to_rom), 32'd0);
      chk("mr cc", cycle_count, 32'd0);
      chk("mr active", 32'(active_layer), 32'd0);
      tick();
      chk("mr idle ena", 32'(layer_ena), 32'd0);
      pulse_start();
      chk("mr arm0 ena", 32'(layer_ena), 32'h1);
      chk("mr arm0 rst_n", 32'(layer_rst_n), 32'h6);
      wait_done("mr finish");
      chk("mr fin cc", cycle_count, 32'd18);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
